efpga_selfwrite_ctrl: RTL and testbench

Sequencer that loads eFPGA configuration words through the fabric's self-write port (SelfWriteStrobe/SelfWriteData) from an on-chip host stream. It also arbitrates that port against the built-in UART bitstream loader. It sits beside `eFPGA_top` inside the eFPGA core wrapper. It accepts a counted frame of 32-bit words over a valid/ready stream, buffers them in a small FIFO, and issues paced single-cycle write strobes. It aborts cleanly if the UART loader becomes active.

---
 rtl/efpga_selfwrite_ctrl_pkg.sv | 18 +
 rtl/efpga_selfwrite_ctrl_if.sv | 25 ++
 rtl/efpga_selfwrite_ctrl_fifo.sv | 54 +++++
 rtl/efpga_selfwrite_ctrl.sv | 163 ++++++++++++++++
 tb/tb_efpga_selfwrite_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/efpga_selfwrite_ctrl_pkg.sv
// Shared types and defaults for the eFPGA self-write sequencer.
// Imported by the stream interface, the word FIFO and the top.
package efpga_cfg_pkg;

  localparam int CFG_DATA_W     = 32;
  localparam int CFG_LEN_W      = 16;
  localparam int CFG_STROBE_GAP = 2;
  localparam int CFG_FIFO_DEPTH = 4;
  localparam int GAP_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/efpga_selfwrite_ctrl_if.sv
// Host word stream into the self-write sequencer.
// The host drives valid/data, the sequencer answers with ready.
interface efpga_selfwrite_ctrl_if
  import efpga_cfg_pkg::*;
#(
  parameter int DATA_W = CFG_DATA_W
) ();

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/efpga_selfwrite_ctrl_fifo.sv
// Small synchronous word FIFO, head read from the storage registers.
// No bypass: a word pushed this cycle is visible at the head next cycle.
module cfg_word_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_q;
  logic [AW:0]       rd_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_q[AW-1:0]];

  // Storage write; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_q[AW-1:0]] <= din;
    end
  end

  // Read/write pointers with wrap bit; flush empties in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/efpga_selfwrite_ctrl.sv
// Paced loader of configuration words into the fabric self-write port.
// Yields the port to the UART loader by aborting the running frame.
module efpga_selfwrite_ctrl
  import efpga_cfg_pkg::*;
#(
  parameter int DATA_W     = CFG_DATA_W,
  parameter int FIFO_DEPTH = CFG_FIFO_DEPTH,
  parameter int STROBE_GAP = CFG_STROBE_GAP,
  parameter int LEN_W      = CFG_LEN_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        frame_len,
  efpga_selfwrite_ctrl_if.slave   host,
  input  logic                    uart_active,
  output logic                    self_write_strobe,
  output logic [DATA_W-1:0]       self_write_data,
  output logic                    busy,
  output logic                    done,
  output logic                    abort,
  output logic [LEN_W-1:0]        words_written
);

  state_t            state_q;
  state_t            state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  acc_q;
  logic [LEN_W-1:0]  ww_q;
  logic [GAP_W-1:0]  gap_q;
  logic [DATA_W-1:0] last_q;
  logic              abort_q;

  logic              f_full;
  logic              f_empty;
  logic [DATA_W-1:0] f_head;

  logic              active;
  logic              kill;
  logic              start_ok;
  logic              ready;
  logic              accept;
  logic              issue;
  logic              last_issue;

  assign active     = (state_q == ST_STREAM) ||
                      (state_q == ST_DRAIN);
  assign kill       = active && uart_active;
  assign start_ok   = (state_q == ST_IDLE) &&
                      start && !uart_active;
  assign ready      = (state_q == ST_STREAM) && !f_full &&
                      (acc_q < len_q) && !uart_active;
  assign accept     = host.s_valid && ready;
  assign issue      = active && !uart_active &&
                      !f_empty && (gap_q == '0);
  assign last_issue = issue && ((ww_q + 1'b1) == len_q);

  assign host.s_ready      = ready;
  assign self_write_strobe = issue;
  // Head word goes out with the strobe; otherwise repeat the last one.
  assign self_write_data   = issue ? f_head : last_q;
  assign busy              = active;
  assign done              = (state_q == ST_FINISH);
  assign abort             = abort_q;
  assign words_written     = ww_q;

  cfg_word_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (host.s_data),
    .pop   (issue),
    .flush (kill),
    .dout  (f_head),
    .full  (f_full),
    .empty (f_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; an abort outranks every other event.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        unique case (1'b1)
          kill:
            state_d = ST_IDLE;
          (len_q == '0):
            state_d = ST_FINISH;
          (accept && ((acc_q + 1'b1) == len_q)):
            state_d = ST_DRAIN;
          default: ;
        endcase
      end
      ST_DRAIN: begin
        unique case (1'b1)
          kill:
            state_d = ST_IDLE;
          last_issue:
            state_d = ST_FINISH;
          (f_empty && (ww_q == len_q)):
            state_d = ST_FINISH;
          default: ;
        endcase
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame counters, abort pulse and the last issued word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      acc_q   <= '0;
      ww_q    <= '0;
      last_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= kill;
      if (start_ok) begin
        len_q <= frame_len;
        acc_q <= '0;
        ww_q  <= '0;
      end else begin
        if (accept) acc_q <= acc_q + 1'b1;
        if (issue)  ww_q  <= ww_q + 1'b1;
      end
      if (issue) last_q <= f_head;
    end
  end

  // Inter-strobe gap timer, cleared so each frame starts unthrottled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q <= '0;
    end else begin
      unique case (1'b1)
        start_ok:         gap_q <= '0;
        issue:            gap_q <= GAP_W'(STROBE_GAP);
        (gap_q != '0):    gap_q <= gap_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_efpga_selfwrite_ctrl.sv
// Directed bench for the self-write sequencer.
// Instance A uses a gap of 2, instance B back-to-back strobes.
module tb_efpga_selfwrite_ctrl;
  import efpga_cfg_pkg::*;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;

  logic          start_a = 1'b0;
  logic          uart_a = 1'b0;
  logic [LW-1:0] len_a = '0;
  logic          strobe_a;
  logic [DW-1:0] wdata_a;
  logic          busy_a;
  logic          done_a;
  logic          abort_a;
  logic [LW-1:0] ww_a;

  logic          start_b = 1'b0;
  logic          uart_b = 1'b0;
  logic [LW-1:0] len_b = '0;
  logic          strobe_b;
  logic [DW-1:0] wdata_b;
  logic          busy_b;
  logic          done_b;
  logic          abort_b;
  logic [LW-1:0] ww_b;

  int checks = 0;
  int errors = 0;

  efpga_selfwrite_ctrl_if #(.DATA_W(DW)) if_a ();
  efpga_selfwrite_ctrl_if #(.DATA_W(DW)) if_b ();

  always #5 clk = ~clk;

  efpga_selfwrite_ctrl #(
    .DATA_W(DW), .FIFO_DEPTH(4), .STROBE_GAP(2), .LEN_W(LW)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .frame_len(len_a), .host(if_a),
    .uart_active(uart_a),
    .self_write_strobe(strobe_a),
    .self_write_data(wdata_a),
    .busy(busy_a), .done(done_a), .abort(abort_a),
    .words_written(ww_a)
  );

  efpga_selfwrite_ctrl #(
    .DATA_W(DW), .FIFO_DEPTH(4), .STROBE_GAP(0), .LEN_W(LW)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .frame_len(len_b), .host(if_b),
    .uart_active(uart_b),
    .self_write_strobe(strobe_b),
    .self_write_data(wdata_b),
    .busy(busy_b), .done(done_b), .abort(abort_b),
    .words_written(ww_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int ns;
    int acc;
    int late;
    int dones;
    int prev_acc;
    logic [31:0] exp_d;

    if_a.s_valid = 1'b0;
    if_a.s_data  = '0;
    if_b.s_valid = 1'b0;
    if_b.s_data  = '0;

    // Reset state.
    #2;
    chk("rst_strobe", 32'(strobe_a), 32'd0);
    chk("rst_data", wdata_a, 32'd0);
    chk("rst_ready", 32'(if_a.s_ready), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_abort", 32'(abort_a), 32'd0);
    chk("rst_ww", 32'(ww_a), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Nominal frame: 3 words, gap 2.
    start_a = 1'b1;
    len_a = 16'd3;
    if_a.s_valid = 1'b1;
    if_a.s_data = 32'hA5A50001;
    idx = 0;
    ns = 0;
    #1;
    chk("nom_ready_idle", 32'(if_a.s_ready), 32'd0);
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if_a.s_data = 32'hA5A50001 + 32'(idx);
      #1;
      chk("nom_strobe", 32'(strobe_a),
          32'(c == 2 || c == 5 || c == 8));
      if (c == 2 || c == 5 || c == 8) begin
        exp_d = 32'hA5A50001 + 32'(ns);
        chk("nom_data", wdata_a, exp_d);
        ns++;
      end
      chk("nom_done", 32'(done_a), 32'(c == 9));
      chk("nom_busy", 32'(busy_a), 32'(c >= 1 && c <= 8));
      if (c == 9) chk("nom_ww_done", 32'(ww_a), 32'd3);
      if (if_a.s_valid && if_a.s_ready) idx++;
      tick();
    end
    chk("nom_accepts", 32'(idx), 32'd3);
    chk("nom_ww", 32'(ww_a), 32'd3);

    // Zero-length frame.
    start_a = 1'b1;
    len_a = 16'd0;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk("zero_ready", 32'(if_a.s_ready), 32'd0);
      chk("zero_strobe", 32'(strobe_a), 32'd0);
      chk("zero_done", 32'(done_a), 32'(c == 2));
      chk("zero_busy", 32'(busy_a), 32'(c == 1));
      tick();
    end
    chk("zero_ww", 32'(ww_a), 32'd0);

    // Start blocked by the UART loader.
    uart_a = 1'b1;
    start_a = 1'b1;
    len_a = 16'd3;
    tick();
    start_a = 1'b0;
    #1;
    chk("blk_busy", 32'(busy_a), 32'd0);
    chk("blk_ready", 32'(if_a.s_ready), 32'd0);
    chk("blk_done", 32'(done_a), 32'd0);
    chk("blk_abort", 32'(abort_a), 32'd0);
    tick();
    uart_a = 1'b0;
    tick();
    chk("blk_busy2", 32'(busy_a), 32'd0);

    // Abort after the second strobe.
    start_a = 1'b1;
    len_a = 16'd6;
    idx = 0;
    ns = 0;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      uart_a = (c == 8);
      if_a.s_data = 32'hB0000001 + 32'(idx);
      #1;
      chk("abt_strobe", 32'(strobe_a), 32'(c == 2 || c == 5));
      if (c == 2 || c == 5) begin
        exp_d = 32'hB0000001 + 32'(ns);
        chk("abt_data", wdata_a, exp_d);
        ns++;
      end
      chk("abt_pulse", 32'(abort_a), 32'(c == 9));
      chk("abt_busy", 32'(busy_a), 32'(c <= 8));
      chk("abt_done", 32'(done_a), 32'd0);
      if (if_a.s_valid && if_a.s_ready) idx++;
      tick();
    end
    chk("abt_ww", 32'(ww_a), 32'd2);

    // Frame after abort, with a stray start while busy.
    start_a = 1'b1;
    len_a = 16'd2;
    idx = 0;
    ns = 0;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      start_a = (c == 3);
      len_a = (c == 3) ? 16'd5 : 16'd2;
      if_a.s_data = 32'hC0000001 + 32'(idx);
      #1;
      chk("re_strobe", 32'(strobe_a), 32'(c == 2 || c == 5));
      if (c == 2 || c == 5) begin
        exp_d = 32'hC0000001 + 32'(ns);
        chk("re_data", wdata_a, exp_d);
        ns++;
      end
      chk("re_done", 32'(done_a), 32'(c == 6));
      chk("re_busy", 32'(busy_a), 32'(c >= 1 && c <= 5));
      chk("re_abort", 32'(abort_a), 32'd0);
      if (if_a.s_valid && if_a.s_ready) idx++;
      tick();
    end
    start_a = 1'b0;
    chk("re_ww", 32'(ww_a), 32'd2);

    // Back-pressure on B: gap 0, 8 words, host valid every 3rd cycle.
    start_b = 1'b1;
    len_b = 16'd8;
    acc = 0;
    ns = 0;
    late = 0;
    dones = 0;
    prev_acc = 0;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if_b.s_valid = ((c - 1) % 3 == 0);
      if_b.s_data = 32'hD0000000 + 32'(acc);
      #1;
      chk("bp_strobe", 32'(strobe_b), 32'(prev_acc));
      if (strobe_b) begin
        exp_d = 32'hD0000000 + 32'(ns);
        chk("bp_data", wdata_b, exp_d);
        ns++;
      end
      if (acc >= 8 && if_b.s_ready) late++;
      if (done_b) dones++;
      prev_acc = 0;
      if (if_b.s_valid && if_b.s_ready) begin
        acc++;
        prev_acc = 1;
      end
      tick();
    end
    if_b.s_valid = 1'b0;
    chk("bp_strobes", 32'(ns), 32'd8);
    chk("bp_accepts", 32'(acc), 32'd8);
    chk("bp_late_ready", 32'(late), 32'd0);
    chk("bp_dones", 32'(dones), 32'd1);
    chk("bp_ww", 32'(ww_b), 32'd8);

    // Reset during DRAIN.
    start_a = 1'b1;
    len_a = 16'd3;
    idx = 0;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if_a.s_data = 32'hE0000001 + 32'(idx);
      #1;
      if (if_a.s_valid && if_a.s_ready) idx++;
      tick();
    end
    #1;
    chk("mid_ww_before", 32'(ww_a), 32'd1);
    chk("mid_busy_before", 32'(busy_a), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_strobe", 32'(strobe_a), 32'd0);
    chk("mid_data", wdata_a, 32'd0);
    chk("mid_ready", 32'(if_a.s_ready), 32'd0);
    chk("mid_busy", 32'(busy_a), 32'd0);
    chk("mid_done", 32'(done_a), 32'd0);
    chk("mid_abort", 32'(abort_a), 32'd0);
    chk("mid_ww", 32'(ww_a), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    ns = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (strobe_a) ns++;
      tick();
    end
    chk("mid_no_strobe", 32'(ns), 32'd0);
    chk("mid_busy_after", 32'(busy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
